// File: rtl/multdiv_pkg.sv
// Shared types and constants for the 4-bit multiply/divide controller.
// Holds the FSM state encoding, operand width and the signed-magnitude helper.
package multdiv_pkg;

    localparam int MD_WIDTH = 4;
    localparam logic [MD_WIDTH-1:0] MD_MOST_NEG = 4'h8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_WAIT,
        ST_DIV_CHECK,
        ST_DIV_RUN,
        ST_DIV_FIX
    } state_t;

    // Magnitude of a two's complement value; the most-negative value maps to 4'b1000.
    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v);
        return v[MD_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/multdiv4_ctrl_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational, zero latency, no flow control.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // The partial remainder stays below the divisor, so the extra top bit of the
    // trial difference is a reliable sign bit.
    assign shifted  = {rem_in, din};
    assign trial    = shifted - {2'b00, divisor};
    assign q_bit    = ~trial[WIDTH+1];
    assign rem_next = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/multdiv4_ctrl.sv
// Multiply/divide issue stage: multiply completes MULT_WAIT+1 edges after accept, divide WIDTH+2 (2 for special cases).
// No backpressure: requests are sampled only in IDLE and dropped otherwise; completion is a one-cycle pulse.
module multdiv4_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH     = MD_WIDTH,
    parameter int MULT_WAIT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_out,
    input  logic             mul_ovf,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = (MULT_WAIT < 1) ? 1 : $clog2(MULT_WAIT + 1);
    localparam int SW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] op_a, op_b;
    logic [CW-1:0]    wait_cnt;
    logic [SW-1:0]    step_cnt;
    logic [WIDTH-1:0] dvd, dvs, quo;
    logic [WIDTH:0]   rem, rem_nx;
    logic             q_bit, q_neg, fix_exc;
    logic             div_zero, div_ovf, wait_done, run_done;

    assign mul_a     = op_a;
    assign mul_b     = op_b;
    assign busy      = (state != ST_IDLE);
    assign div_zero  = (op_b == '0);
    assign div_ovf   = (op_a == MD_MOST_NEG) && (op_b == '1);
    assign wait_done = (wait_cnt == CW'(MULT_WAIT));
    assign run_done  = (step_cnt == SW'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in   (rem),
        .din      (dvd[WIDTH-1]),
        .divisor  (dvs),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (ctrl_MULT)     state_n = ST_MUL_WAIT;
                else if (ctrl_DIV) state_n = ST_DIV_CHECK;
            end
            ST_MUL_WAIT:  if (wait_done) state_n = ST_IDLE;
            ST_DIV_CHECK: state_n = (div_zero || div_ovf) ? ST_DIV_FIX : ST_DIV_RUN;
            ST_DIV_RUN:   if (run_done) state_n = ST_DIV_FIX;
            ST_DIV_FIX:   state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_a           <= '0;
            op_b           <= '0;
            wait_cnt       <= '0;
            step_cnt       <= '0;
            dvd            <= '0;
            dvs            <= '0;
            quo            <= '0;
            rem            <= '0;
            q_neg          <= 1'b0;
            fix_exc        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctrl_MULT || ctrl_DIV) begin
                        op_a     <= data_operandA;
                        op_b     <= data_operandB;
                        wait_cnt <= '0;
                        step_cnt <= '0;
                    end
                end
                ST_MUL_WAIT: begin
                    if (wait_done) begin
                        data_result    <= mul_out;
                        data_exception <= mul_ovf;
                        data_resultRDY <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_DIV_CHECK: begin
                    // Special cases park their answer in quo and finish through DIV_FIX unsigned.
                    q_neg <= 1'b0;
                    if (div_zero) begin
                        quo     <= '0;
                        fix_exc <= 1'b1;
                    end else if (div_ovf) begin
                        quo     <= MD_MOST_NEG;
                        fix_exc <= 1'b1;
                    end else begin
                        dvd      <= md_abs(op_a);
                        dvs      <= md_abs(op_b);
                        rem      <= '0;
                        quo      <= '0;
                        q_neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        fix_exc  <= 1'b0;
                        step_cnt <= '0;
                    end
                end
                ST_DIV_RUN: begin
                    rem      <= rem_nx;
                    dvd      <= dvd << 1;
                    quo      <= {quo[WIDTH-2:0], q_bit};
                    step_cnt <= step_cnt + SW'(1);
                end
                ST_DIV_FIX: begin
                    data_result    <= q_neg ? -quo : quo;
                    data_exception <= fix_exc;
                    data_resultRDY <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv4_ctrl.sv
// Scoreboard bench for multdiv4_ctrl: driver pushes expected results, monitor pops on data_resultRDY.
module tb_multdiv4_ctrl;

    localparam int W  = 4;
    localparam int MW = 1;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] data_operandA, data_operandB;
    logic         ctrl_MULT, ctrl_DIV;
    logic [W-1:0] mul_a, mul_b, mul_out;
    logic         mul_ovf;
    logic [W-1:0] data_result;
    logic         data_exception, data_resultRDY, busy;

    multdiv4_ctrl #(.WIDTH(W), .MULT_WAIT(MW)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_out        (mul_out),
        .mul_ovf        (mul_ovf),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Combinational signed array multiplier stub.
    int prod;
    always_comb begin
        prod    = int'($signed(mul_a)) * int'($signed(mul_b));
        mul_out = prod[3:0];
        mul_ovf = (prod > 7) || (prod < -8);
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] res;
        bit         exc;
        int         due;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] prev_res = 4'h0;
    bit         prev_exc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Reference model from the arithmetic rules; latency in edges after the accept edge.
    task automatic model(input bit m, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] r, output bit e, output int lat);
        int ia, ib, v;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (m) begin
            v   = ia * ib;
            r   = v[3:0];
            e   = (v > 7) || (v < -8);
            lat = MW + 1;
        end else if (ib == 0) begin
            r = 4'h0; e = 1'b1; lat = 2;
        end else if (ia == -8 && ib == -1) begin
            r = 4'h8; e = 1'b1; lat = 2;
        end else begin
            v   = ia / ib;
            r   = v[3:0];
            e   = 1'b0;
            lat = W + 2;
        end
    endtask

    // Called at a falling edge; returns at the falling edge right after completion.
    task automatic do_op(input bit m, input bit d, input logic [3:0] a, input logic [3:0] b,
                         input int inject_at, input int reset_at);
        logic [3:0] er;
        bit         ee;
        int         lat, e0, done;
        exp_t       ent;
        model(m, a, b, er, ee, lat);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        e0   = cyc + 1;
        done = e0 + lat;
        if (reset_at == 0) begin
            ent.res = er; ent.exc = ee; ent.due = done;
            sb.push_back(ent);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 4'($urandom);
        data_operandB = 4'($urandom);
        while (cyc < done) begin
            chk("mul_a_held", mul_a, a);
            chk("mul_b_held", mul_b, b);
            chk("busy_high", busy, 1);
            chk("result_held", data_result, prev_res);
            chk("exc_held", data_exception, prev_exc);
            if (reset_at > 0 && cyc == e0 + reset_at - 1) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_result", data_result, 0);
                chk("rst_exc", data_exception, 0);
                chk("rst_rdy", data_resultRDY, 0);
                chk("rst_mul_a", mul_a, 0);
                chk("rst_mul_b", mul_b, 0);
                prev_res = 4'h0;
                prev_exc = 1'b0;
                return;
            end
            ctrl_MULT = (inject_at > 0 && cyc == e0 + inject_at - 1);
            ctrl_DIV  = ctrl_MULT;
            @(negedge clock);
        end
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        chk("busy_low_done", busy, 0);
        prev_res = er;
        prev_exc = ee;
    endtask

    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rdy", data_resultRDY, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", data_result, mon_e.res);
                chk("exception", data_exception, mon_e.exc);
                chk("rdy_cycle", cyc, mon_e.due);
            end
        end else if (sb.size() > 0 && cyc >= sb[0].due) begin
            mon_e = sb.pop_front();
            chk("missed_rdy", data_resultRDY, 1);
        end
    end

    always @(posedge clock) begin
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycle %0d exceeded limit %0d", cyc, 20000);
            $fatal(1);
        end
    end

    initial begin
        bit         m, d;
        int         kind, gap;
        logic [3:0] a, b;
        reset = 1'b1;
        data_operandA = 4'h0;
        data_operandB = 4'h0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_mul_a", mul_a, 0);
        chk("reset_mul_b", mul_b, 0);
        chk("reset_result", data_result, 0);
        chk("reset_exc", data_exception, 0);
        chk("reset_rdy", data_resultRDY, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        @(negedge clock);

        do_op(1, 0, 4'h3, 4'hE, 0, 0);   // 3 * -2
        do_op(0, 1, 4'h7, 4'hE, 0, 0);   // 7 / -2
        do_op(0, 1, 4'h9, 4'h2, 0, 0);   // -7 / 2
        do_op(0, 1, 4'h6, 4'h3, 0, 0);
        do_op(0, 1, 4'h5, 4'h0, 0, 0);   // divide by zero
        do_op(0, 1, 4'h8, 4'hF, 0, 0);   // -8 / -1
        do_op(0, 1, 4'h7, 4'hE, 3, 0);   // requests during a divide are dropped
        do_op(1, 1, 4'h3, 4'h3, 0, 0);   // both high: multiply wins
        do_op(0, 1, 4'h6, 4'hE, 0, 3);   // reset aborts mid-divide
        do_op(0, 1, 4'h6, 4'h3, 0, 0);
        do_op(1, 0, 4'h2, 4'h3, 0, 0);   // back-to-back in the RDY cycle
        do_op(1, 0, 4'h7, 4'h7, 0, 0);
        do_op(0, 1, 4'h8, 4'h3, 0, 0);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 3);
            m = (kind == 0) || (kind == 3);
            d = (kind != 0);
            a = 4'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                a = 4'h8;
                b = 4'hF;
            end
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clock);
            do_op(m, d, a, b, 0, 0);
        end

        repeat (8) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
